// File: rtl/approx_error_accumulator.sv
// Error statistics for an approximate adder: compares approx_sum against op_a+op_b over a run of n samples.
// Latency: a sample accepted at edge t is reflected in every statistic after edge t+2; done rises at t+3.
// Backpressure: in_ready is high only in RUN while fewer than n_samples have been accepted.
module approx_error_accumulator #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_abs_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Run control: latched sample target and number of samples accepted so far.
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] acc_cnt_q;

  // Stage 1: exact sum and the approximate result captured side by side.
  logic             s1_vld_q;
  logic [W:0]       s1_exact_q;
  logic [W:0]       s1_approx_q;

  // Stage 2: absolute error ready to be folded into the statistics.
  logic             s2_vld_q;
  logic [W:0]       s2_abs_q;
  logic [W:0]       abs_err;

  // Statistics registers and their next-state values.
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sum_abs_err_q, sum_abs_err_d;
  logic [W:0]       max_abs_err_q, max_abs_err_d;
  logic [ACC_W:0]   sum_ext;

  logic accept;
  logic last_accept;
  logic start_ok;
  logic pipe_empty;

  assign in_ready    = (state_q == RUN) && (acc_cnt_q < n_q);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt_q == (n_q - CNT_W'(1)));
  // Start is only honoured between runs; a start during RUN/DRAIN is dropped.
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign pipe_empty  = !s1_vld_q && !s2_vld_q;

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_err_q;
  assign max_abs_err = max_abs_err_q;

  // Next-state logic; clear overrides everything else and parks the block in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave only after the final sample has reached the statistics.
        if (pipe_empty) begin
          state_d = DONE;
        end
      end
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run control: capture the target on an accepted start, count handshakes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      n_q       <= '0;
      acc_cnt_q <= '0;
    end else if (start_ok) begin
      n_q       <= n_samples;
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  // Stage 1: full-width exact sum, no truncation of the carry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld_q    <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_exact_q  <= {1'b0, op_a} + {1'b0, op_b};
        s1_approx_q <= approx_sum;
      end
    end
  end

  // Unsigned magnitude of the difference, subtracting the smaller from the larger.
  always_comb begin
    abs_err = '0;
    if (s1_exact_q >= s1_approx_q) begin
      abs_err = s1_exact_q - s1_approx_q;
    end else begin
      abs_err = s1_approx_q - s1_exact_q;
    end
  end

  // Stage 2: register the absolute error.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s2_vld_q <= 1'b0;
      s2_abs_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_abs_q <= abs_err;
      end
    end
  end

  // One extra bit catches the carry out of the error sum for saturation.
  assign sum_ext = {1'b0, sum_abs_err_q} + (ACC_W+1)'(s2_abs_q);

  // Statistics update: a fresh run zeroes them, otherwise fold in each stage-2 sample with saturation.
  always_comb begin
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    sum_abs_err_d = sum_abs_err_q;
    max_abs_err_d = max_abs_err_q;
    if (start_ok) begin
      sample_cnt_d  = '0;
      err_cnt_d     = '0;
      sum_abs_err_d = '0;
      max_abs_err_d = '0;
    end else if (s2_vld_q) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
      if ((s2_abs_q != '0) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      sum_abs_err_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (s2_abs_q > max_abs_err_q) begin
        max_abs_err_d = s2_abs_q;
      end
    end
  end

  // Statistics registers; reset and clear discard everything.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
    end else begin
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      sum_abs_err_q <= sum_abs_err_d;
      max_abs_err_q <= max_abs_err_d;
    end
  end

endmodule

// File: tb/tb_approx_error_accumulator.sv
// Bench for approx_error_accumulator: directed cases plus randomized runs against a statistics model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: samples are only counted in the model when in_valid and in_ready coincide.
module tb_approx_error_accumulator;

  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W:0]       approx_sum;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] sum_abs_err;
  logic [W:0]       max_abs_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Sample vectors for the next run.
  logic [W-1:0] va [16];
  logic [W-1:0] vb [16];
  logic [W:0]   vs [16];

  approx_error_accumulator #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .n_samples  (n_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input longint unsigned c, input longint unsigned e,
                           input longint unsigned s, input longint unsigned m);
    chk({tag, "_sample_cnt"}, sample_cnt, c);
    chk({tag, "_err_cnt"}, err_cnt, e);
    chk({tag, "_sum"}, sum_abs_err, s);
    chk({tag, "_max"}, max_abs_err, m);
  endtask

  // mode 0: in_valid always high; 1: random gaps; 2: pattern 1,0,0 repeating.
  // noise: spurious start pulses with random n_samples while the run is in progress.
  task automatic run_vec(input string tag, input int n, input int mode, input bit noise);
    longint unsigned e_cnt = 0, e_err = 0, e_sum = 0, e_max = 0;
    longint unsigned exact, apx, ae;
    int acc = 0;
    int cyc = 0;
    int k = 0;
    bit take;
    n_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    while (acc < n && cyc < 2000) begin
      case (mode)
        0:       in_valid = 1'b1;
        2:       in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      op_a       = va[acc];
      op_b       = vb[acc];
      approx_sum = vs[acc];
      if (noise) begin
        start     = ($urandom_range(0, 3) == 0);
        n_samples = $urandom;
      end
      take = in_valid && in_ready;
      tick();
      start = 1'b0;
      if (take) begin
        exact = longint'(va[acc]) + longint'(vb[acc]);
        apx   = longint'(vs[acc]);
        ae    = (exact > apx) ? exact - apx : apx - exact;
        if (e_cnt < 64'hFFFF_FFFF) e_cnt++;
        if (ae != 0 && e_err < 64'hFFFF_FFFF) e_err++;
        e_sum = e_sum + ae;
        if (e_sum > 64'hFFFF_FFFF_FFFF) e_sum = 64'hFFFF_FFFF_FFFF;
        if (ae > e_max) e_max = ae;
        acc++;
      end
      cyc++;
    end
    if (cyc >= 2000) chk({tag, "_accept_timeout"}, acc, n);
    chk({tag, "_rdy_after_last"}, in_ready, 0);
    // Keep offering data: nothing more may be taken once the target is met.
    in_valid   = 1'b1;
    op_a       = 16'h1234;
    op_b       = 16'h4321;
    approx_sum = '0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk({tag, "_done_latency"}, k, 3);
    chk({tag, "_busy_done"}, busy, 0);
    chk_stats(tag, e_cnt, e_err, e_sum, e_max);
    repeat (3) tick();
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_cnt_hold"}, sample_cnt, e_cnt);
    chk({tag, "_sum_hold"}, sum_abs_err, e_sum);
  endtask

  task automatic fill_random(input int n);
    longint unsigned ex;
    for (int i = 0; i < n; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      ex    = longint'(va[i]) + longint'(vb[i]);
      case ($urandom_range(0, 2))
        0:       vs[i] = (W+1)'(ex);
        1:       vs[i] = (W+1)'(ex ^ longint'($urandom_range(1, 255)));
        default: vs[i] = (W+1)'($urandom);
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; n_samples = '0;
    in_valid = 1'b0; op_a = '0; op_b = '0; approx_sum = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_stats("rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Exact sums only, including the carry into bit W.
    va[0] = 16'h0001; vb[0] = 16'h0002; vs[0] = 17'h00003;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vs[1] = 17'h10000;
    va[2] = 16'h0000; vb[2] = 16'h0000; vs[2] = 17'h00000;
    run_vec("exact", 3, 0, 1'b0);
    chk_stats("exact_const", 3, 0, 0, 0);
    chk("exact_done", done, 1);

    // Two erroneous samples.
    va[0] = 16'h0001; vb[0] = 16'h0001; vs[0] = 17'h00000;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vs[1] = 17'h18000;
    run_vec("err2", 2, 0, 1'b0);
    chk_stats("err2_const", 2, 2, 64'h8000, 64'h7FFE);

    // Gapped in_valid 1,0,0,1 with spurious starts during the run.
    va[0] = 16'd3;  vb[0] = 16'd4;  vs[0] = 17'd0;
    va[1] = 16'd10; vb[1] = 16'd20; vs[1] = 17'd40;
    run_vec("gap", 2, 2, 1'b1);
    chk_stats("gap_const", 2, 2, 17, 10);

    // Zero-length run from DONE: one cycle to DONE, statistics wiped.
    n_samples = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk_stats("zero", 0, 0, 0, 0);

    fill_random(12);
    run_vec("rnd_a", 12, 1, 1'b1);

    // Clear beats start in the same cycle.
    n_samples = 5;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_in_ready", in_ready, 0);
    chk_stats("clr", 0, 0, 0, 0);
    tick();
    chk("clr_still_idle", busy, 0);

    // Reset one cycle after the first of four samples is accepted.
    fill_random(4);
    n_samples = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    op_a = 16'h0100; op_b = 16'h0200; approx_sum = 17'h00000;
    chk("mid_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk_stats("mid_rst", 0, 0, 0, 0);
    repeat (3) tick();
    chk_stats("mid_rst_later", 0, 0, 0, 0);
    run_vec("after_rst", 4, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_vec($sformatf("rnd%0d", r), n, int'($urandom_range(0, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
